onehot_demux: RTL and testbench

Registered 1-to-NUM_OUT stream demultiplexer: the inverse of the team's one-hot-select mux. Each accepted input beat carries a one-hot destination select; the block resolves it with lowest-index priority, holds the beat in a single-entry output register, and presents it on exactly one output lane under a valid/ready handshake. Beats with an all-zero select are consumed and discarded. It sits between a single producer and up to NUM_OUT consumers on the datapath fan-out side.

---
 rtl/onehot_demux_pkg.sv | 20 ++
 rtl/onehot_prio.sv | 18 +
 rtl/onehot_demux.sv | 103 ++++++++++
 tb/tb_onehot_demux.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_demux_pkg.sv
// Shared constants and one-hot helpers for the onehot_demux stream demultiplexer.
// Helpers operate on a MaxOut-wide vector; callers zero-extend and truncate.
package onehot_demux_pkg;

  localparam int unsigned DefNumOut = 4;
  localparam int unsigned DefDataW  = 8;
  localparam int unsigned DefCntW   = 8;
  localparam int unsigned MaxOut    = 32;

  // Two's-complement trick: keeps only the lowest set bit.
  function automatic logic [MaxOut-1:0] lowest_onehot(input logic [MaxOut-1:0] vec);
    return vec & (~vec + MaxOut'(1));
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic is_multi_hot(input logic [MaxOut-1:0] vec);
    return |(vec & (vec - MaxOut'(1)));
  endfunction

endpackage

// File: rtl/onehot_prio.sv
// Combinational lowest-index priority resolver for the demux select.
// NUM_OUT must lie in 2..MaxOut.
module onehot_prio
  import onehot_demux_pkg::*;
#(
  parameter int unsigned NUM_OUT = DefNumOut
) (
  input  logic [NUM_OUT-1:0] sel,
  output logic [NUM_OUT-1:0] dest,
  output logic               multi,
  output logic               none
);

  assign dest  = NUM_OUT'(lowest_onehot(MaxOut'(sel)));
  assign multi = is_multi_hot(MaxOut'(sel));
  assign none  = ~|sel;

endmodule

// File: rtl/onehot_demux.sv
// Registered 1-to-NUM_OUT demultiplexer with a single-entry output register.
// Define DEMUX_DROP_CNT_EN to build the saturating zero-select drop counter.
module onehot_demux
  import onehot_demux_pkg::*;
#(
  parameter int unsigned NUM_OUT = DefNumOut,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic [NUM_OUT-1:0] sel_i,
  output logic [NUM_OUT-1:0] out_valid_o,
  input  logic [NUM_OUT-1:0] out_ready_i,
  output logic [DATA_W-1:0]  out_data_o,
  output logic               multi_hot_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  logic               valid_q, valid_d;
  logic [NUM_OUT-1:0] dest_q, dest_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               multi_q, multi_d;

  logic [NUM_OUT-1:0] dest;
  logic               multi;
  logic               none;
  logic               drain;
  logic               accept;

  onehot_prio #(
    .NUM_OUT (NUM_OUT)
  ) u_prio (
    .sel   (sel_i),
    .dest  (dest),
    .multi (multi),
    .none  (none)
  );

  // Only the destination lane's ready matters; other lanes never stall a beat.
  assign drain      = valid_q & |(dest_q & out_ready_i);
  assign in_ready_o = ~valid_q | drain;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    data_d  = data_q;
    multi_d = accept & multi;
    if (accept && !none) begin
      valid_d = 1'b1;
      dest_d  = dest;
      data_d  = in_data_i;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      multi_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      multi_q <= multi_d;
    end
  end

  assign out_valid_o = valid_q ? dest_q : '0;
  assign out_data_o  = data_q;
  assign multi_hot_o = multi_q;

`ifdef DEMUX_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && none && (drop_cnt_q != {CNT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_onehot_demux.sv
// Scoreboard bench for onehot_demux: stimulus pushes expected beats, a monitor
// pops them on every output handshake.
module tb_onehot_demux;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_data_i;
  logic [3:0] sel_i;
  logic [3:0] out_valid_o;
  logic [3:0] out_ready_i;
  logic [7:0] out_data_o;
  logic       multi_hot_o;
  logic [7:0] drop_cnt_o;

  typedef struct {
    logic [3:0] lane;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   hs_cnt = 0;

`ifdef DEMUX_DROP_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  onehot_demux #(
    .NUM_OUT (4),
    .DATA_W  (8),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .sel_i       (sel_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .multi_hot_o (multi_hot_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every handshake on the destination lane against the queue.
  always @(negedge clk) begin
    if (!reset && |out_valid_o) begin
      total++;
      if (!$onehot(out_valid_o)) begin
        bad++;
        $display("FAIL onehot_valid: got %b expected one bit", out_valid_o);
      end
    end
    if (!reset && |(out_valid_o & out_ready_i)) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got lane %b data %h expected none", out_valid_o,
                 out_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_lane", 32'(out_valid_o), 32'(e.lane));
        chk("mon_data", 32'(out_data_o), 32'(e.data));
      end
    end
  end

  // Present a beat until accepted; returns at posedge+1 after the accepting edge.
  task automatic beat(input logic [3:0] sel, input logic [7:0] data, input logic [3:0] lane,
                      output int stalls);
    exp_t e;
    in_valid_i = 1'b1;
    sel_i      = sel;
    in_data_i  = data;
    stalls     = 0;
    @(negedge clk);
    while (!in_ready_o && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!in_ready_o) begin
      chk("accept_timeout", 32'(in_ready_o), 32'd1);
    end else if (sel != 4'b0000) begin
      e.lane = lane;
      e.data = data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int stall_sum;
    int hs0;
    reset       = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = 8'h00;
    sel_i       = 4'b0000;
    out_ready_i = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_data", 32'(out_data_o), 32'h0);
    chk("rst_multi", 32'(multi_hot_o), 32'h0);
    chk("rst_drop", 32'(drop_cnt_o), 32'h0);
    chk("rst_ready", 32'(in_ready_o), 32'h1);

    // Single beat to lane 2, drained immediately.
    @(posedge clk);
    #1;
    out_ready_i = 4'b0100;
    beat(4'b0100, 8'hA5, 4'b0100, st);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid_o), 32'h4);
    chk("t1_ready", 32'(in_ready_o), 32'h1);

    // Back-to-back round robin at full throughput.
    @(posedge clk);
    #1;
    out_ready_i = 4'b1111;
    stall_sum   = 0;
    hs0         = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      beat(4'(1 << (i % 4)), 8'h10 + 8'(i), 4'(1 << (i % 4)), st);
      stall_sum += st;
    end
    @(negedge clk);
    #1;
    chk("rr_stalls", 32'(stall_sum), 32'd0);
    chk("rr_handshakes", 32'(hs_cnt - hs0), 32'd8);
    chk("rr_multi", 32'(multi_hot_o), 32'h0);

    // Hold on lane 2 while other lanes are ready.
    @(posedge clk);
    #1;
    out_ready_i = 4'b1011;
    beat(4'b0100, 8'h5A, 4'b0100, st);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid_o), 32'h4);
      chk("hold_data", 32'(out_data_o), 32'h5A);
      chk("hold_ready", 32'(in_ready_o), 32'h0);
    end
    @(posedge clk);
    #1;
    out_ready_i = 4'b1111;
    @(negedge clk);
    chk("hold_release_ready", 32'(in_ready_o), 32'h1);

    // Multi-hot select resolves to the lowest lane and pulses the flag once.
    @(posedge clk);
    #1;
    beat(4'b1010, 8'h3C, 4'b0010, st);
    @(negedge clk);
    chk("multi_pulse", 32'(multi_hot_o), 32'h1);
    chk("multi_lane", 32'(out_valid_o), 32'h2);
    @(negedge clk);
    chk("multi_clear", 32'(multi_hot_o), 32'h0);

    // Drain and zero-select accept in the same cycle.
    @(posedge clk);
    #1;
    out_ready_i = 4'b0000;
    beat(4'b0010, 8'h11, 4'b0010, st);
    out_ready_i = 4'b0010;
    beat(4'b0000, 8'hEE, 4'b0000, st);
    @(negedge clk);
    chk("dz_valid", 32'(out_valid_o), 32'h0);
    chk("dz_drop", 32'(drop_cnt_o), CntEn ? 32'd1 : 32'd0);

    // Many zero-select beats: counter saturates, nothing is emitted.
    @(posedge clk);
    #1;
    out_ready_i = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      beat(4'b0000, 8'(i), 4'b0000, st);
    end
    @(negedge clk);
    chk("drop_sat", 32'(drop_cnt_o), CntEn ? 32'd255 : 32'd0);
    chk("drop_valid", 32'(out_valid_o), 32'h0);

    // Reset while a beat is held on lane 3.
    @(posedge clk);
    #1;
    out_ready_i = 4'b0000;
    beat(4'b1000, 8'h77, 4'b1000, st);
    @(negedge clk);
    chk("prerst_valid", 32'(out_valid_o), 32'h8);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_valid", 32'(out_valid_o), 32'h0);
    chk("mrst_data", 32'(out_data_o), 32'h0);
    chk("mrst_drop", 32'(drop_cnt_o), 32'h0);
    chk("mrst_ready", 32'(in_ready_o), 32'h1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
